// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter driving a shared enable-gated register bank
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REGS-1:0]         reg_en,
    output logic [DATA_W-1:0]           reg_d,
    output logic                        addr_err,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    win;
    logic [PTR_W:0]      cand;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REQ-1:0]  gnt_next;
    logic [NUM_REGS-1:0] en_next;
    logic                err_next;
    logic [PTR_W-1:0]    ptr_next;

    // The requester holding gnt this cycle is masked so a late-dropped req is not re-granted.
    assign eligible = req & ~gnt;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && eligible[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        gnt_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_addr    = req_addr[i*ADDR_W +: ADDR_W];
                win_data    = req_data[i*DATA_W +: DATA_W];
                gnt_next[i] = 1'b1;
            end
        end
    end

    // Out-of-range addresses enable no word and raise addr_err instead.
    always_comb begin
        en_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            en_next[r] = (32'(win_addr) == r);
        end
        err_next = (32'(win_addr) >= NUM_REGS);
        ptr_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            reg_en   <= '0;
            reg_d    <= '0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
        end else begin
            busy <= |eligible;
            if (!hold && found) begin
                gnt      <= gnt_next;
                reg_en   <= en_next;
                reg_d    <= win_data;
                addr_err <= err_next;
                ptr      <= ptr_next;
            end else begin
                gnt      <= '0;
                reg_en   <= '0;
                addr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - table-driven scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic        hold;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;

    logic [3:0]  gnt8, gnt6;
    logic [7:0]  en8;
    logic [5:0]  en6;
    logic [7:0]  d8, d6;
    logic        err8, err6, busy8, busy6;

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .DATA_W(8), .ADDR_W(3)) u_dut8 (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt8), .reg_en(en8), .reg_d(d8), .addr_err(err8), .busy(busy8)
    );

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .DATA_W(8), .ADDR_W(3)) u_dut6 (
        .clk(clk), .reset(reset), .hold(hold), .req(req),
        .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt6), .reg_en(en6), .reg_d(d6), .addr_err(err6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         hld;
        logic [3:0] rq;
        logic [3:0] g;
        bit         b;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] en8;
        logic [5:0] en6;
        logic [7:0] d;
        logic       err6;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;
    int   vidx  = 0;

    // requester 3..0 addresses 3,5,7,1 ; data D3,A5,71,10
    logic [11:0] addr_tab = 12'h779;
    logic [31:0] data_tab = 32'hD3A57110;
    logic [7:0]  model_d  = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, vidx, act, exp);
        end
    endtask

    function automatic void add(bit r, bit h, logic [3:0] q, logic [3:0] g, bit b);
        vec_t v;
        v.rst = r; v.hld = h; v.rq = q; v.g = g; v.b = b;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        int   w;
        logic [2:0] a;
        reset    = v.rst;
        hold     = v.hld;
        req      = v.rq;
        req_addr = addr_tab;
        req_data = data_tab;
        w = 0;
        for (int i = 0; i < 4; i++) if (v.g[i]) w = i;
        a = addr_tab[w*3 +: 3];
        e.gnt  = v.g;
        e.busy = v.b;
        e.en8  = '0;
        e.en6  = '0;
        e.err6 = 1'b0;
        if (v.rst) begin
            model_d = 8'h00;
        end else if (v.g != 4'b0) begin
            e.en8   = 8'd1 << a;
            e.en6   = (a < 3'd6) ? (6'd1 << a) : 6'd0;
            e.err6  = (a >= 3'd6);
            model_d = data_tab[w*8 +: 8];
        end
        e.d = model_d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("gnt8", gnt8, e.gnt);
        chk("gnt6", gnt6, e.gnt);
        chk("reg_en8", en8, e.en8);
        chk("reg_en6", en6, e.en6);
        chk("reg_d8", d8, e.d);
        chk("reg_d6", d6, e.d);
        chk("addr_err8", err8, 1'b0);
        chk("addr_err6", err6, e.err6);
        chk("busy8", busy8, e.busy);
        chk("busy6", busy6, e.busy);
        vidx++;
    endtask

    initial begin
        logic [3:0]  pg, pq;
        logic [11:0] pa;
        logic        ph;
        int          w;

        reset = 1'b1; hold = 1'b0; req = '0; req_addr = '0; req_data = '0;

        // rst hold req   gnt     busy
        add(1, 0, 4'b1111, 4'b0000, 0);
        add(1, 0, 4'b1111, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b0001, 1);
        add(0, 0, 4'b1111, 4'b0010, 1);
        add(0, 0, 4'b1111, 4'b0100, 1);
        add(0, 0, 4'b1111, 4'b1000, 1);
        add(0, 0, 4'b1111, 4'b0001, 1);
        add(0, 0, 4'b1111, 4'b0010, 1);
        add(0, 0, 4'b1111, 4'b0100, 1);
        add(0, 0, 4'b1111, 4'b1000, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 1, 4'b0011, 4'b0000, 1);
        add(0, 1, 4'b0011, 4'b0000, 1);
        add(0, 1, 4'b0011, 4'b0000, 1);
        add(0, 0, 4'b0011, 4'b0001, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0100, 4'b0100, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b1111, 4'b1000, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0001, 4'b0001, 1);
        add(0, 0, 4'b0001, 4'b0000, 0);
        add(0, 0, 4'b0001, 4'b0001, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b1000, 4'b1000, 1);
        add(1, 0, 4'b1000, 4'b0000, 0);
        add(0, 0, 4'b1000, 4'b1000, 1);
        add(0, 0, 4'b1001, 4'b0001, 1);
        add(1, 0, 4'b1001, 4'b0000, 0);
        add(0, 0, 4'b1001, 4'b0001, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0010, 4'b0010, 1);
        add(0, 0, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0011, 4'b0001, 1);
        add(1, 1, 4'b1111, 4'b0000, 0);
        add(0, 0, 4'b0011, 4'b0001, 1);
        add(0, 0, 4'b0011, 4'b0010, 1);
        add(0, 0, 4'b0011, 4'b0001, 1);
        add(0, 0, 4'b0011, 4'b0010, 1);

        foreach (vecs[i]) apply(vecs[i]);

        // Random stimulus: check invariants that hold regardless of arbitration order.
        for (int n = 0; n < 60; n++) begin
            reset    = 1'b0;
            hold     = ($urandom_range(0, 3) == 0);
            req      = 4'($urandom);
            req_addr = 12'($urandom);
            req_data = $urandom;
            pg = gnt8; pq = req; pa = req_addr; ph = hold;
            @(posedge clk);
            #1;
            chk("onehot_gnt", $onehot0(gnt8), 1'b1);
            chk("onehot_en", $onehot0(en8), 1'b1);
            chk("en_implies_gnt", (en8 == 8'd0) || (gnt8 != 4'd0), 1'b1);
            chk("no_back_to_back", gnt8 & pg, 4'b0);
            chk("gnt_subset_req", gnt8 & ~pq, 4'b0);
            chk("hold_blocks", ph && (gnt8 != 4'd0), 1'b0);
            chk("busy_rand", busy8, |(pq & ~pg));
            if (gnt8 != 4'd0) begin
                w = 0;
                for (int i = 0; i < 4; i++) if (gnt8[i]) w = i;
                chk("en_matches_addr", en8, 8'd1 << pa[w*3 +: 3]);
            end
            vidx++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one bank of enable-gated D flip-flop registers (NUM_REGS words × DATA_W bits) between NUM_REQ write requesters.
- Picks one requester per cycle by round-robin and returns a one-cycle grant.
- Drives the bank's one-hot per-word enable vector and a common data bus, so at most one register word is written per clock.
- Sits between datapath units and the register bank; the bank's flip-flops are not part of this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of register words in the bank.
- DATA_W, 8, width of each register word.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high, sampled on rising edge of clk.
- hold  input  1  stall; while 1 no new grants are issued.
- req  input  NUM_REQ  per-requester write request, level.
- req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant pulse, registered.
- reg_en  output  NUM_REGS  one-hot enable to the bank's flip-flop en inputs, registered.
- reg_d  output  DATA_W  data to the bank's flip-flop d inputs, registered.
- addr_err  output  1  pulse: the granted address was >= NUM_REGS.
- busy  output  1  registered; 1 when any unmasked req was pending at the last edge.

Behaviour:
- Reset:
  - When reset=1 at a rising edge: gnt=0, reg_en=0, reg_d=0, addr_err=0, busy=0, ptr=0.
  - Reset takes priority over all other inputs.
  - Reset mid-grant: the gnt/reg_en pulse is cut after the reset edge, and a requester that was granted in that cycle has still completed its write.
- Round-robin pointer:
  - ptr holds the highest-priority index.
  - Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ.
- Arbitration at each rising edge (reset=0):
  - eligible = req & ~gnt. The requester currently holding gnt is masked, so a req held one cycle too long is not re-granted back-to-back.
  - If hold=1 or eligible==0: gnt, reg_en, addr_err go to 0; reg_d keeps its value; ptr is unchanged.
  - Otherwise, with w = first eligible index in search order, the outputs registered at that edge are:
    - gnt = 1<<w
    - reg_d = req_data[w]
    - reg_en = 1<<req_addr[w] if req_addr[w] < NUM_REGS, else 0 with addr_err=1
    - ptr = (w+1) mod NUM_REQ
- Latency:
  - A req sampled at edge t gives gnt/reg_en high during cycle t..t+1.
  - The bank captures reg_d at edge t+1.
- Requester handshake:
  - Requester holds req, addr and data stable until it sees gnt=1.
  - Requester drops req no later than the edge after gnt. A req still high one cycle after that edge counts as a new request.
- Invariants:
  - gnt and reg_en are each one-hot or zero.
  - reg_en != 0 only when gnt != 0.
  - Never more than one word enabled.
- busy: set at an edge if eligible != 0 (hold ignored), else 0.
- Throughput: one write per cycle when ≥2 requesters alternate. A single requester gets at most one grant every 2 cycles.

Test Plan:
- Reset: assert reset 2 cycles with req=4'b1111 → gnt=0, reg_en=0, reg_d=0, busy=0. First grant after release goes to requester 0.
- Single write: req[2]=1, req_addr[2]=5, req_data[2]=8'hA5 at edge t → at t: gnt=4'b0100, reg_en=8'b0010_0000, reg_d=8'hA5, all for one cycle; ptr=3.
- Round-robin fairness: all four req held high for 8 cycles with the mask applied → grant order 0,1,2,3,0,1,2,3. Every cycle gnt is one-hot and reg_en matches that requester's address.
- Hold: req=4'b0011 with hold=1 for 3 cycles → gnt=0, busy=1, ptr unchanged. hold=0 → gnt=4'b0001 on the next edge.
- Address error: NUM_REGS=6, req[1]=1, req_addr[1]=7 → gnt=4'b0010, reg_en=0, addr_err=1 for one cycle; ptr advances to 2.
- Reset mid-grant: reset=1 on the edge after gnt=4'b1000 → all outputs 0, ptr=0. The retained req[3] is granted 1 cycle after reset deasserts, unless req[0..2] are also pending.
